memory_controller: RTL and testbench



---
 rtl/memory_controller_if.sv | 35 +++
 rtl/memory_controller.sv | 124 ++++++++++++
 tb/tb_memory_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/memory_controller_if.sv
// CPU request port and byte-wide external SRAM bus of memory_controller,
// plus a read-only view of the controller state.
interface memory_controller_if;
    // CPU side: mem_read_en/mem_write_en are held high until the one-cycle mem_ack;
    // external side: a strobe stays up until ext_ready is seen with it (or timeout).
    logic [15:0] mem_addr;
    logic [15:0] mem_data_out;
    logic        mem_read_en;
    logic        mem_write_en;
    logic        dbl_byte_en;
    logic [15:0] mem_data_in;
    logic        mem_ack;
    logic        bus_error;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_re;
    logic        ext_we;
    logic [7:0]  ext_rdata;
    logic        ext_ready;
    logic [2:0]  dbg_state;

    modport slave (
        input  mem_addr, mem_data_out, mem_read_en, mem_write_en, dbl_byte_en,
        input  ext_rdata, ext_ready,
        output mem_data_in, mem_ack, bus_error,
        output ext_addr, ext_wdata, ext_re, ext_we, dbg_state
    );

    modport master (
        output mem_addr, mem_data_out, mem_read_en, mem_write_en, dbl_byte_en,
        output ext_rdata, ext_ready,
        input  mem_data_in, mem_ack, bus_error,
        input  ext_addr, ext_wdata, ext_re, ext_we, dbg_state
    );
endinterface

// File: rtl/memory_controller.sv
// Executes 8/16-bit CPU reads and writes as little-endian byte transfers on an
// external ready-handshake bus, with a per-byte timeout and one-cycle ack.
module memory_controller #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [15:0] ERR_DATA       = 16'hFFFF
) (
    input  logic clk,
    input  logic nrst,
    memory_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, BYTE0, BYTE1, ACK, HOLDOFF} state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t      state, next_state;
    logic [15:0] addr_q, wdata_q, rdata_q, ext_addr_q;
    logic [7:0]  lo_q;
    logic        dbl_q, write_q, err_q;
    logic [CW-1:0] cnt;
    logic        req, in_byte, timeout;
    logic        re_c, we_c, ack_c, err_c;
    logic [7:0]  wdata_c;

    assign req     = bus.mem_write_en | bus.mem_read_en;
    assign in_byte = (state == BYTE0) || (state == BYTE1);
    assign timeout = in_byte && !bus.ext_ready && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        re_c       = 1'b0;
        we_c       = 1'b0;
        wdata_c    = 8'h00;
        ack_c      = 1'b0;
        err_c      = 1'b0;
        case (state)
            IDLE:    if (req) next_state = BYTE0;
            BYTE0: begin
                re_c    = !write_q;
                we_c    = write_q;
                wdata_c = write_q ? wdata_q[7:0] : 8'h00;
                if (bus.ext_ready) next_state = dbl_q ? BYTE1 : ACK;
                else if (timeout)  next_state = ACK;
            end
            BYTE1: begin
                re_c    = !write_q;
                we_c    = write_q;
                wdata_c = write_q ? wdata_q[15:8] : 8'h00;
                if (bus.ext_ready || timeout) next_state = ACK;
            end
            ACK: begin
                ack_c      = 1'b1;
                err_c      = err_q;
                next_state = HOLDOFF;
            end
            HOLDOFF: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request fields are latched once in IDLE so later input changes cannot leak in.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            dbl_q      <= 1'b0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            lo_q       <= 8'h00;
            cnt        <= '0;
            ext_addr_q <= 16'h0000;
            rdata_q    <= 16'h0000;
        end else begin
            case (state)
                IDLE: if (req) begin
                    addr_q     <= bus.mem_addr;
                    wdata_q    <= bus.mem_data_out;
                    dbl_q      <= bus.dbl_byte_en;
                    write_q    <= bus.mem_write_en;
                    err_q      <= 1'b0;
                    cnt        <= '0;
                    ext_addr_q <= bus.mem_addr;
                end
                BYTE0: begin
                    if (bus.ext_ready) begin
                        lo_q <= bus.ext_rdata;
                        cnt  <= '0;
                        if (dbl_q)         ext_addr_q <= addr_q + 16'd1;
                        else if (!write_q) rdata_q    <= {8'h00, bus.ext_rdata};
                    end else if (timeout) begin
                        err_q <= 1'b1;
                        if (!write_q) rdata_q <= ERR_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BYTE1: begin
                    if (bus.ext_ready) begin
                        if (!write_q) rdata_q <= {bus.ext_rdata, lo_q};
                    end else if (timeout) begin
                        err_q <= 1'b1;
                        if (!write_q) rdata_q <= ERR_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ext_re      = re_c;
    assign bus.ext_we      = we_c;
    assign bus.ext_wdata   = wdata_c;
    assign bus.ext_addr    = ext_addr_q;
    assign bus.mem_ack     = ack_c;
    assign bus.bus_error   = err_c;
    assign bus.mem_data_in = rdata_q;
    assign bus.dbg_state   = state;
endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: table of single transactions against a
// byte-array SRAM, plus reset, enable-overlap and abort sequences.
module tb_memory_controller;
    logic clk;
    logic nrst;
    memory_controller_if bus_if ();

    memory_controller dut (.clk(clk), .nrst(nrst), .bus(bus_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram [0:65535];
    int checks = 0;
    int passed = 0;

    typedef struct {
        logic wr, rd, dbl, rdy;
        logic [15:0] addr, wdata;
        int lat;
        logic [15:0] data;
        logic err;
        int nstb;
        logic [15:0] a0, a1;
        logic re;
        logic [15:0] chk_a;
        logic [7:0] chk_b;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input logic wr, rd, dbl, input logic [15:0] addr, wdata);
        bus_if.mem_write_en = wr;
        bus_if.mem_read_en  = rd;
        bus_if.dbl_byte_en  = dbl;
        bus_if.mem_addr     = addr;
        bus_if.mem_data_out = wdata;
    endtask

    // Called at a negedge while the DUT is in IDLE; returns at a negedge in IDLE.
    task automatic run_txn(input logic wr, rd, dbl, input logic [15:0] addr, wdata,
                           output int lat, output logic [15:0] data, output logic err,
                           output int nstb, output logic [15:0] a0, a1,
                           output logic re_seen, output logic ack_after);
        lat = -1; data = 16'h0; err = 1'b0; nstb = 0; a0 = 16'h0; a1 = 16'h0; re_seen = 1'b0;
        set_req(wr, rd, dbl, addr, wdata);
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (bus_if.ext_re || bus_if.ext_we) begin
                if (nstb == 0) a0 = bus_if.ext_addr;
                a1 = bus_if.ext_addr;
                nstb++;
                if (bus_if.ext_re) re_seen = 1'b1;
                if (bus_if.ext_we && bus_if.ext_ready) ram[bus_if.ext_addr] = bus_if.ext_wdata;
            end
            bus_if.ext_rdata = ram[bus_if.ext_addr];
            if (bus_if.mem_ack) begin
                lat  = k;
                data = bus_if.mem_data_in;
                err  = bus_if.bus_error;
                break;
            end
        end
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        cycle();
        ack_after = bus_if.mem_ack;
        cycle();
    endtask

    initial begin
        int lat, nstb, acks, res;
        logic [15:0] data, a0, a1;
        logic err, re_seen, ack_after;

        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h1234] = 8'hA5;
        ram[16'hFFFF] = 8'h34;
        ram[16'h0000] = 8'h12;
        ram[16'h4001] = 8'h5A;

        //            wr    rd    dbl   rdy   addr      wdata     lat data      err   nstb a0        a1        re    chk_a     chk_b
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h0000, 2,  16'h00A5, 1'b0, 1,  16'h1234, 16'h1234, 1'b1, 16'h1234, 8'hA5};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h2000, 16'hBEEF, 3,  16'h00A5, 1'b0, 2,  16'h2000, 16'h2001, 1'b0, 16'h2001, 8'hBE};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 3,  16'h1234, 1'b0, 2,  16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 8'h34};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h3000, 16'h0077, 2,  16'h1234, 1'b0, 1,  16'h3000, 16'h3000, 1'b0, 16'h3000, 8'h77};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h4000, 16'hAB12, 2,  16'h1234, 1'b0, 1,  16'h4000, 16'h4000, 1'b0, 16'h4001, 8'h5A};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h2000, 16'h0000, 3,  16'hBEEF, 1'b0, 2,  16'h2000, 16'h2001, 1'b1, 16'h2000, 8'hEF};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1000, 16'h0000, 17, 16'hFFFF, 1'b1, 16, 16'h1000, 16'h1000, 1'b1, 16'h1000, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h5000, 16'h1122, 17, 16'hFFFF, 1'b1, 16, 16'h5000, 16'h5000, 1'b0, 16'h5000, 8'h00};

        nrst = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        bus_if.ext_rdata = 8'h00;
        bus_if.ext_ready = 1'b1;
        cycle();
        cycle();
        check("reset_ack",   bus_if.mem_ack, 0);
        check("reset_err",   bus_if.bus_error, 0);
        check("reset_re_we", {bus_if.ext_re, bus_if.ext_we}, 0);
        check("reset_addr",  bus_if.ext_addr, 0);
        check("reset_data",  bus_if.mem_data_in, 0);
        check("reset_state", bus_if.dbg_state, 0);
        nrst = 1'b1;
        cycle();

        for (int v = 0; v < 8; v++) begin
            bus_if.ext_ready = vecs[v].rdy;
            run_txn(vecs[v].wr, vecs[v].rd, vecs[v].dbl, vecs[v].addr, vecs[v].wdata,
                    lat, data, err, nstb, a0, a1, re_seen, ack_after);
            check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
            check($sformatf("v%0d_data", v), data, vecs[v].data);
            check($sformatf("v%0d_bus_error", v), err, vecs[v].err);
            check($sformatf("v%0d_strobes", v), nstb, vecs[v].nstb);
            check($sformatf("v%0d_addr0", v), a0, vecs[v].a0);
            check($sformatf("v%0d_addr_last", v), a1, vecs[v].a1);
            check($sformatf("v%0d_re_seen", v), re_seen, vecs[v].re);
            check($sformatf("v%0d_ram", v), ram[vecs[v].chk_a], vecs[v].chk_b);
            check($sformatf("v%0d_ack_single", v), ack_after, 0);
        end
        bus_if.ext_ready = 1'b1;

        // Both enables held high through HOLDOFF: one write, one ack.
        acks = 0; res = 0;
        set_req(1'b1, 1'b1, 1'b0, 16'h6000, 16'h00C3);
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (bus_if.mem_ack) acks++;
            if (bus_if.ext_re) res++;
            if (bus_if.ext_we) ram[bus_if.ext_addr] = bus_if.ext_wdata;
            if (k == 3) set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        end
        check("hold_acks", acks, 1);
        check("hold_no_re", res, 0);
        check("hold_ram", ram[16'h6000], 8'hC3);

        // Reset during BYTE1 of a 16-bit read aborts with no ack.
        set_req(1'b0, 1'b1, 1'b1, 16'h0100, 16'h0);
        cycle();
        cycle();
        check("abort_in_byte1", bus_if.dbg_state, 3'd2);
        check("abort_addr1", bus_if.ext_addr, 16'h0101);
        #2 nrst = 1'b0;
        #1;
        check("abort_re_we", {bus_if.ext_re, bus_if.ext_we}, 0);
        check("abort_addr", bus_if.ext_addr, 0);
        check("abort_data", bus_if.mem_data_in, 0);
        check("abort_state", bus_if.dbg_state, 0);
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        acks = 0;
        @(negedge clk);
        nrst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (bus_if.mem_ack) acks++;
        end
        check("abort_no_ack", acks, 0);
        run_txn(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0, lat, data, err, nstb, a0, a1, re_seen, ack_after);
        check("post_abort_latency", lat, 2);
        check("post_abort_data", data, 16'h00A5);
        check("post_abort_err", err, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
